// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// This block is the initiator side of the 16-bit ALU breadboard interface.
// It accepts one operation command at a time over a valid/ready handshake.
// It drives the ALU operand and opcode inputs from registers, waits a
// programmable settle time, and then captures the ALU result and error.
// The captured values go back to the consumer over a valid/ready response
// handshake. A 32-bit accumulator keeps the last error-free result so that
// chained operations can reuse it as operand A.
//
// Parameters:
//   WIDTH   operand width (ALU input width)
//   RES_W   result width (ALU result width)
//   SETTLE  cycles the ALU inputs are held before capture (1..15)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   cmd_valid   command present
//   cmd_ready   sequencer can accept a command (state is IDLE)
//   cmd_a       operand A
//   cmd_b       operand B
//   cmd_op      ALU opcode (0 add, 1 sub, 2 mul, 3 div, 4 mod)
//   cmd_acc     use acc[WIDTH-1:0] in place of cmd_a
//   alu_a       registered operand A to the ALU
//   alu_b       registered operand B to the ALU
//   alu_op      registered opcode to the ALU
//   alu_result  ALU result
//   alu_error   ALU error (bit0 add/sub overflow, bit1 divide/mod by zero)
//   rsp_valid   response present
//   rsp_ready   consumer accepts the response
//   rsp_result  captured result
//   rsp_error   captured error
//   acc         accumulator value
//   busy        high whenever the state is not IDLE
//
// Optional feature macro: ALU_ILLEGAL_OP_CHECK_EN
//   When this macro is defined, the block does not issue opcodes above 4 to
//   the ALU. Instead, it answers one cycle after acceptance with a zero
//   result and error 2'b11. When the macro is undefined, every opcode is
//   forwarded to the ALU.
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int WIDTH  = 16,
  parameter int RES_W  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [RES_W-1:0] alu_result,
  input  logic [1:0]       alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic [1:0]       rsp_error,
  output logic [RES_W-1:0] acc,
  output logic             busy
);

  // The counter reaches zero on the cycle before capture.
  // Loading SETTLE-1 therefore puts rsp_valid at edge N+SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]       rsp_error_q, rsp_error_d;
  logic [RES_W-1:0] acc_q, acc_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic             illegal_q, illegal_d;
`endif

  // Next-state and datapath logic.
  // The ALU input registers change only when a command is accepted.
  // The response registers change only on capture or at the handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    acc_d        = acc_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    illegal_d    = illegal_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_WAIT;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          // An illegal opcode leaves the ALU inputs untouched.
          // It takes a single WAIT cycle so that the response appears at N+1.
          illegal_d = (cmd_op > 4'd4);
          if (cmd_op > 4'd4) begin
            cnt_d = '0;
          end else begin
            alu_a_d  = cmd_acc ? acc_q[WIDTH-1:0] : cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
            cnt_d    = SETTLE_LOAD;
          end
`else
          alu_a_d  = cmd_acc ? acc_q[WIDTH-1:0] : cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          cnt_d    = SETTLE_LOAD;
`endif
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_error_d  = alu_error;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          if (illegal_q) begin
            rsp_result_d = '0;
            rsp_error_d  = 2'b11;
          end
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        // The accumulator only takes error-free results.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          if (rsp_error_q == 2'b00) begin
            acc_d = rsp_result_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Reset discards any pending command or response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= '0;
      acc_q        <= '0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      acc_q        <= acc_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  // cmd_ready and busy are decoded from the registered state only.
  // This means rsp_ready has no combinational path to cmd_ready.
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign acc        = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Bench for alu_cmd_sequencer. A behavioural ALU answers the sequencer's
// registered operands. A transaction-level model tracks the accumulator,
// the expected ALU inputs, the response and the response latency.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int WIDTH  = 16;
  localparam int RES_W  = 32;
  localparam int SETTLE = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       cmd_op;
  logic             cmd_acc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [RES_W-1:0] alu_result;
  logic [1:0]       alu_error;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic [1:0]       rsp_error;
  logic [RES_W-1:0] acc;
  logic             busy;

  int vectors    = 0;
  int miscompares = 0;

  // Transaction-level model state
  logic [31:0] m_acc;
  logic [15:0] m_alu_a;
  logic [15:0] m_alu_b;
  logic [3:0]  m_alu_op;

  alu_cmd_sequencer #(
    .WIDTH (WIDTH),
    .RES_W (RES_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_acc   (cmd_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .alu_error (alu_error),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_error (rsp_error),
    .acc       (acc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {error, result}.
  // Add and subtract wrap to 16 bits and flag signed overflow in bit 0.
  // Divide and mod by zero return 0 and set bit 1.
  function automatic logic [33:0] alu_model(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [3:0]  op);
    logic [15:0] t;
    logic [31:0] r;
    logic [1:0]  e;
    r = '0;
    e = '0;
    case (op)
      4'd0: begin
        t = a + b;
        r = {16'b0, t};
        e[0] = (a[15] == b[15]) && (t[15] != a[15]);
      end
      4'd1: begin
        t = a - b;
        r = {16'b0, t};
        e[0] = (a[15] != b[15]) && (t[15] != a[15]);
      end
      4'd2: r = 32'(a) * 32'(b);
      4'd3: if (b == 16'd0) e = 2'b10; else r = {16'b0, a / b};
      4'd4: if (b == 16'd0) e = 2'b10; else r = {16'b0, a % b};
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  assign {alu_error, alu_result} = alu_model(alu_a, alu_b, alu_op);

  // One compare: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one command through acceptance, settle, optional backpressure
  // (with stray cmd_valid pulses), and the response handshake.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op, input logic use_acc,
                               input int hold, input logic poke);
    logic [15:0] eff_a;
    logic [33:0] ref_v;
    logic        illegal;
    logic [31:0] exp_res;
    logic [1:0]  exp_err;
    int          lat;
    int          cycles;
    int          guard;

    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    eff_a   = use_acc ? m_acc[15:0] : a;
    illegal = 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    illegal = (op > 4'd4);
`endif
    if (illegal) begin
      exp_res = '0;
      exp_err = 2'b11;
      lat     = 1;
    end else begin
      ref_v    = alu_model(eff_a, b, op);
      exp_res  = ref_v[31:0];
      exp_err  = ref_v[33:32];
      lat      = SETTLE;
      m_alu_a  = eff_a;
      m_alu_b  = b;
      m_alu_op = op;
    end

    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_acc   = use_acc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a     = 16'($urandom);
    cmd_b     = 16'($urandom);
    cmd_acc   = 1'($urandom);

    checkOutput("alu_a", 32'(alu_a), 32'(m_alu_a));
    checkOutput("alu_b", 32'(alu_b), 32'(m_alu_b));
    checkOutput("alu_op", 32'(alu_op), 32'(m_alu_op));
    checkOutput("busy_accept", 32'(busy), 32'd1);
    checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);

    cycles = 0;
    while (!rsp_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("rsp_latency", 32'(cycles), 32'(lat));
    checkOutput("rsp_result", rsp_result, exp_res);
    checkOutput("rsp_error", 32'(rsp_error), 32'(exp_err));

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        cmd_valid = 1'b1;
        cmd_a     = 16'($urandom);
        cmd_op    = 4'($urandom);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_result", rsp_result, exp_res);
      checkOutput("hold_rsp_error", 32'(rsp_error), 32'(exp_err));
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("hold_alu_a", 32'(alu_a), 32'(m_alu_a));
      checkOutput("hold_alu_op", 32'(alu_op), 32'(m_alu_op));
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (exp_err == 2'b00) m_acc = exp_res;
    checkOutput("rsp_valid_done", 32'(rsp_valid), 32'd0);
    checkOutput("busy_done", 32'(busy), 32'd0);
    checkOutput("acc", acc, m_acc);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_b;

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_acc   = 1'b0;
    rsp_ready = 1'b0;
    m_acc     = '0;
    m_alu_a   = '0;
    m_alu_b   = '0;
    m_alu_op  = '0;

    // Check the reset state, then release reset.
    #12;
    checkOutput("reset_alu_a", 32'(alu_a), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_acc", acc, 32'd0);
    #7 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed commands:
    //   add
    //   accumulator chain
    //   sub
    //   mul with backpressure
    //   divide by zero
    //   accumulator with upper bits set
    //   overflow
    //   opcode above 4
    applyStimulus(16'd15, 16'd126, 4'd0, 1'b0, 0, 1'b0);
    applyStimulus(16'hABCD, 16'd9, 4'd0, 1'b1, 0, 1'b0);
    applyStimulus(16'd15, 16'd126, 4'd1, 1'b0, 1, 1'b0);
    applyStimulus(16'd15, 16'd126, 4'd2, 1'b0, 5, 1'b1);
    applyStimulus(16'd62463, 16'd0, 4'd3, 1'b0, 0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 4'd2, 1'b0, 0, 1'b0);
    applyStimulus(16'h1234, 16'd1, 4'd0, 1'b1, 0, 1'b0);
    applyStimulus(16'h7FFF, 16'd1, 4'd0, 1'b0, 0, 1'b0);
    applyStimulus(16'd77, 16'd5, 4'd9, 1'b0, 2, 1'b1);

    // Make sure acc is nonzero so that the reset clear is observable.
    applyStimulus(16'd300, 16'd45, 4'd0, 1'b0, 0, 1'b0);

    // Assert reset in the middle of WAIT. The outputs should clear without a clock edge.
    cmd_valid = 1'b1;
    cmd_a     = 16'd1000;
    cmd_b     = 16'd7;
    cmd_op    = 4'd2;
    cmd_acc   = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_alu_a", 32'(alu_a), 32'd0);
    checkOutput("midreset_alu_b", 32'(alu_b), 32'd0);
    checkOutput("midreset_alu_op", 32'(alu_op), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_rsp_result", rsp_result, 32'd0);
    checkOutput("midreset_rsp_error", 32'(rsp_error), 32'd0);
    checkOutput("midreset_acc", acc, 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    #3 rst = 1'b1;
    m_acc    = '0;
    m_alu_a  = '0;
    m_alu_b  = '0;
    m_alu_op = '0;
    @(posedge clk); #1;
    checkOutput("midreset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomised commands against the model.
    for (int n = 0; n < 24; n++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                         : 4'($urandom_range(0, 4));
      r_b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      applyStimulus(16'($urandom), r_b, r_op, 1'($urandom),
                    $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
